// File: rtl/frame_gen_pkg.sv
// Shared definitions for the frame timing source and the pattern generator:
// FSM state encoding and the default timing constants both instances use.
package frame_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FGAP,
    VPRE,
    HPRE,
    ACT,
    HPOST,
    LGAP,
    VPOST
  } state_t;

  localparam int DEF_DVAL_HIGH = 640;
  localparam int DEF_ROW_COUNT = 480;
  localparam int DEF_H_PRE     = 4;
  localparam int DEF_H_POST    = 4;
  localparam int DEF_LINE_GAP  = 16;
  localparam int DEF_V_PRE     = 8;
  localparam int DEF_V_POST    = 8;
  localparam int DEF_FRAME_GAP = 32;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_timing_gen.sv
// Camera-link style frame timing source: fval/lval/dval levels plus the
// fval_posedge and lval_negedge strobes, pixel and line indices.
// Optional feature macro: FRAME_TIMING_STATS_EN (live completed-frame counter
// on frame_cnt; when undefined frame_cnt is tied to 0).
module frame_timing_gen
  import frame_gen_pkg::*;
#(
  parameter int DVAL_HIGH = DEF_DVAL_HIGH,
  parameter int ROW_COUNT = DEF_ROW_COUNT,
  parameter int H_PRE     = DEF_H_PRE,
  parameter int H_POST    = DEF_H_POST,
  parameter int LINE_GAP  = DEF_LINE_GAP,
  parameter int V_PRE     = DEF_V_PRE,
  parameter int V_POST    = DEF_V_POST,
  parameter int FRAME_GAP = DEF_FRAME_GAP
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  output logic                               fval,
  output logic                               lval,
  output logic                               dval,
  output logic                               fval_posedge,
  output logic                               lval_negedge,
  output logic [$clog2(DVAL_HIGH+1)-1:0]     pix_x,
  output logic [$clog2(ROW_COUNT+1)-1:0]     line_idx,
  output logic [15:0]                        frame_cnt
);

  localparam int PX_W    = $clog2(DVAL_HIGH + 1);
  localparam int LI_W    = $clog2(ROW_COUNT + 1);
  localparam int MAX_LEN = max_of(max_of(max_of(DVAL_HIGH, H_PRE), max_of(H_POST, LINE_GAP)),
                                  max_of(max_of(V_PRE, V_POST), FRAME_GAP));
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [LI_W-1:0] LAST_LINE = LI_W'(ROW_COUNT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             last;

  // Next-state decode: cnt holds the cycles remaining in the current state,
  // and each state hands the next one its full duration on exit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt - CNT_W'(1);
    last      = (cnt == CNT_W'(1));
    case (state)
      IDLE: begin
        cnt_nxt = cnt;
        if (en) begin
          state_nxt = FGAP;
          cnt_nxt   = CNT_W'(FRAME_GAP);
        end
      end
      FGAP: begin
        if (last) begin
          if (en) begin
            state_nxt = VPRE;
            cnt_nxt   = CNT_W'(V_PRE);
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
      end
      VPRE: begin
        if (last) begin
          state_nxt = HPRE;
          cnt_nxt   = CNT_W'(H_PRE);
        end
      end
      HPRE: begin
        if (last) begin
          state_nxt = ACT;
          cnt_nxt   = CNT_W'(DVAL_HIGH);
        end
      end
      ACT: begin
        if (last) begin
          state_nxt = HPOST;
          cnt_nxt   = CNT_W'(H_POST);
        end
      end
      HPOST: begin
        if (last) begin
          if (line_idx < LAST_LINE) begin
            state_nxt = LGAP;
            cnt_nxt   = CNT_W'(LINE_GAP);
          end else begin
            state_nxt = VPOST;
            cnt_nxt   = CNT_W'(V_POST);
          end
        end
      end
      LGAP: begin
        if (last) begin
          state_nxt = HPRE;
          cnt_nxt   = CNT_W'(H_PRE);
        end
      end
      VPOST: begin
        if (last) begin
          state_nxt = FGAP;
          cnt_nxt   = CNT_W'(FRAME_GAP);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and remaining-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Levels and strobes registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fval         <= 1'b0;
      lval         <= 1'b0;
      dval         <= 1'b0;
      fval_posedge <= 1'b0;
      lval_negedge <= 1'b0;
    end else begin
      fval         <= (state_nxt inside {VPRE, HPRE, ACT, HPOST, LGAP, VPOST});
      lval         <= (state_nxt inside {HPRE, ACT, HPOST});
      dval         <= (state_nxt == ACT);
      fval_posedge <= (state_nxt == VPRE) && (state != VPRE);
      lval_negedge <= (state == HPOST) && (state_nxt != HPOST);
    end
  end

  // Pixel index counts through ACT; line index clears at frame start and steps when a new line begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x    <= '0;
      line_idx <= '0;
    end else begin
      pix_x <= ((state_nxt == ACT) && (state == ACT)) ? pix_x + 1'b1 : '0;
      if (state_nxt == VPRE) begin
        line_idx <= '0;
      end else if ((state == LGAP) && (state_nxt == HPRE)) begin
        line_idx <= line_idx + 1'b1;
      end
    end
  end

`ifdef FRAME_TIMING_STATS_EN
  logic [15:0] frame_cnt_q;

  // Completed-frame counter, bumped as VPOST hands over to the frame gap; wraps at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if ((state == VPOST) && (state_nxt == FGAP)) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule
